// File: rtl/rca_config_bank.sv
`default_nettype none
// ============================================================================
// Module      : rca_config_bank
// Description : Double-buffered (shadow/active) configuration store for a set
//               of reconfigurable custom accelerators, with busy-safe commit.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_config_bank #(
    parameter int NUM_RCAS           = 2,
    parameter int NUM_READ_PORTS     = 5,
    parameter int NUM_WRITE_PORTS    = 2,
    parameter int NUM_GRID_MUXES     = 16,
    parameter int GRID_MUX_INPUTS    = 8,
    parameter int GRID_NUM_ROWS      = 4,
    parameter int IO_UNIT_MUX_INPUTS = 8,
    parameter int CFG_ADDR_W         = 8,
    localparam int GM_W  = $clog2(GRID_MUX_INPUTS),
    localparam int RS_W  = $clog2(GRID_NUM_ROWS),
    localparam int IO_W  = $clog2(IO_UNIT_MUX_INPUTS),
    localparam int RCA_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [2:0]                         cfg_type,
    input  logic [RCA_W-1:0]                   cfg_rca,
    input  logic                               cfg_src_dest,
    input  logic [CFG_ADDR_W-1:0]              cfg_addr,
    input  logic [7:0]                         cfg_data,
    input  logic [NUM_RCAS-1:0]                rca_busy,
    input  logic [RCA_W-1:0]                   use_rca_sel,
    output logic [5*NUM_READ_PORTS-1:0]        src_reg_addrs,
    output logic [5*NUM_WRITE_PORTS-1:0]       dest_reg_addrs,
    output logic [GM_W*NUM_GRID_MUXES-1:0]     grid_mux_sels,
    output logic [IO_W*GRID_NUM_ROWS-1:0]      io_mux_sels,
    output logic [RS_W*NUM_WRITE_PORTS-1:0]    result_mux_sels,
    output logic [NUM_RCAS-1:0]                commit_pending,
    output logic [NUM_RCAS-1:0]                commit_done,
    output logic                               cfg_error
);

    localparam int c_src_w  = 5 * NUM_READ_PORTS;
    localparam int c_dst_w  = 5 * NUM_WRITE_PORTS;
    localparam int c_grid_w = GM_W * NUM_GRID_MUXES;
    localparam int c_io_w   = IO_W * GRID_NUM_ROWS;
    localparam int c_res_w  = RS_W * NUM_WRITE_PORTS;
    localparam int c_pend_w = 1 << RCA_W;

    localparam logic [2:0] c_t_cpu    = 3'd0;
    localparam logic [2:0] c_t_grid   = 3'd1;
    localparam logic [2:0] c_t_io     = 3'd2;
    localparam logic [2:0] c_t_result = 3'd3;
    localparam logic [2:0] c_t_commit = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                r_state    [NUM_RCAS];
    logic [c_src_w-1:0]    r_sh_src   [NUM_RCAS];
    logic [c_dst_w-1:0]    r_sh_dst   [NUM_RCAS];
    logic [c_grid_w-1:0]   r_sh_grid  [NUM_RCAS];
    logic [c_io_w-1:0]     r_sh_io    [NUM_RCAS];
    logic [c_res_w-1:0]    r_sh_res   [NUM_RCAS];
    logic [c_src_w-1:0]    r_act_src  [NUM_RCAS];
    logic [c_dst_w-1:0]    r_act_dst  [NUM_RCAS];
    logic [c_grid_w-1:0]   r_act_grid [NUM_RCAS];
    logic [c_io_w-1:0]     r_act_io   [NUM_RCAS];
    logic [c_res_w-1:0]    r_act_res  [NUM_RCAS];
    logic [NUM_RCAS-1:0]   r_commit_done;
    logic                  r_cfg_error;

    logic [NUM_RCAS-1:0]   w_pending;
    logic [c_pend_w-1:0]   w_pend_ext;
    logic [NUM_RCAS-1:0]   w_hit;
    logic [NUM_RCAS-1:0]   w_copy;
    logic                  w_rca_ok;
    logic                  w_src_ok;
    logic                  w_dst_ok;
    logic                  w_grid_ok;
    logic                  w_io_ok;
    logic                  w_addr_ok;
    logic                  w_legal;
    logic                  w_accept;
    logic                  w_commit;
    logic                  w_unused;

    // Compares are one bit wider so a count equal to 2**width still fits.
    assign w_rca_ok  = {1'b0, cfg_rca}  < (RCA_W + 1)'(NUM_RCAS);
    assign w_src_ok  = {1'b0, cfg_addr} < (CFG_ADDR_W + 1)'(NUM_READ_PORTS);
    assign w_dst_ok  = {1'b0, cfg_addr} < (CFG_ADDR_W + 1)'(NUM_WRITE_PORTS);
    assign w_grid_ok = {1'b0, cfg_addr} < (CFG_ADDR_W + 1)'(NUM_GRID_MUXES);
    assign w_io_ok   = {1'b0, cfg_addr} < (CFG_ADDR_W + 1)'(GRID_NUM_ROWS);
    assign w_unused  = ^cfg_data[7:5];

    always_comb begin
        w_addr_ok = 1'b0;
        case (cfg_type)
            c_t_cpu:    w_addr_ok = cfg_src_dest ? w_dst_ok : w_src_ok;
            c_t_grid:   w_addr_ok = w_grid_ok;
            c_t_io:     w_addr_ok = w_io_ok;
            c_t_result: w_addr_ok = w_dst_ok;
            c_t_commit: w_addr_ok = 1'b1;
            default:    w_addr_ok = 1'b0;
        endcase
    end

    assign w_legal  = w_rca_ok && w_addr_ok;
    assign w_commit = (cfg_type == c_t_commit);
    assign w_accept = cfg_valid && cfg_ready;

    // Out-of-range RCA indices land on zero padding, so they are never stalled.
    assign w_pend_ext = c_pend_w'(w_pending);
    assign cfg_ready  = !w_pend_ext[cfg_rca];

    generate
        for (genvar r = 0; r < NUM_RCAS; r++) begin : g_rca
            assign w_pending[r] = (r_state[r] == ST_PENDING);
            assign w_hit[r]     = w_accept && w_legal && (cfg_rca == RCA_W'(r));
            assign w_copy[r]    = !rca_busy[r] &&
                                  (((r_state[r] == ST_IDLE) && w_hit[r] && w_commit) ||
                                   (r_state[r] == ST_PENDING));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_error   <= 1'b0;
            r_commit_done <= '0;
            for (int r = 0; r < NUM_RCAS; r++) begin
                r_state[r]    <= ST_IDLE;
                r_sh_src[r]   <= '0;
                r_sh_dst[r]   <= '0;
                r_sh_grid[r]  <= '0;
                r_sh_io[r]    <= '0;
                r_sh_res[r]   <= '0;
                r_act_src[r]  <= '0;
                r_act_dst[r]  <= '0;
                r_act_grid[r] <= '0;
                r_act_io[r]   <= '0;
                r_act_res[r]  <= '0;
            end
        end else begin
            r_cfg_error <= w_accept && !w_legal;
            for (int r = 0; r < NUM_RCAS; r++) begin
                r_commit_done[r] <= w_copy[r];
                case (r_state[r])
                    ST_IDLE: begin
                        if (w_hit[r] && w_commit && rca_busy[r]) begin
                            r_state[r] <= ST_PENDING;
                        end
                    end
                    ST_PENDING: begin
                        if (!rca_busy[r]) begin
                            r_state[r] <= ST_IDLE;
                        end
                    end
                    default: r_state[r] <= ST_IDLE;
                endcase
                if (w_copy[r]) begin
                    r_act_src[r]  <= r_sh_src[r];
                    r_act_dst[r]  <= r_sh_dst[r];
                    r_act_grid[r] <= r_sh_grid[r];
                    r_act_io[r]   <= r_sh_io[r];
                    r_act_res[r]  <= r_sh_res[r];
                end
                if (w_hit[r] && !w_commit) begin
                    for (int e = 0; e < NUM_READ_PORTS; e++) begin
                        if (cfg_type == c_t_cpu && !cfg_src_dest && cfg_addr == CFG_ADDR_W'(e))
                            r_sh_src[r][5*e +: 5] <= cfg_data[4:0];
                    end
                    for (int e = 0; e < NUM_WRITE_PORTS; e++) begin
                        if (cfg_type == c_t_cpu && cfg_src_dest && cfg_addr == CFG_ADDR_W'(e))
                            r_sh_dst[r][5*e +: 5] <= cfg_data[4:0];
                        if (cfg_type == c_t_result && cfg_addr == CFG_ADDR_W'(e))
                            r_sh_res[r][RS_W*e +: RS_W] <= cfg_data[RS_W-1:0];
                    end
                    for (int e = 0; e < NUM_GRID_MUXES; e++) begin
                        if (cfg_type == c_t_grid && cfg_addr == CFG_ADDR_W'(e))
                            r_sh_grid[r][GM_W*e +: GM_W] <= cfg_data[GM_W-1:0];
                    end
                    for (int e = 0; e < GRID_NUM_ROWS; e++) begin
                        if (cfg_type == c_t_io && cfg_addr == CFG_ADDR_W'(e))
                            r_sh_io[r][IO_W*e +: IO_W] <= cfg_data[IO_W-1:0];
                    end
                end
            end
        end
    end

    // Zero-latency issue view; an unselected/out-of-range index reads all zeros.
    always_comb begin
        src_reg_addrs   = '0;
        dest_reg_addrs  = '0;
        grid_mux_sels   = '0;
        io_mux_sels     = '0;
        result_mux_sels = '0;
        for (int r = 0; r < NUM_RCAS; r++) begin
            if (use_rca_sel == RCA_W'(r)) begin
                src_reg_addrs   = r_act_src[r];
                dest_reg_addrs  = r_act_dst[r];
                grid_mux_sels   = r_act_grid[r];
                io_mux_sels     = r_act_io[r];
                result_mux_sels = r_act_res[r];
            end
        end
    end

    assign commit_pending = w_pending;
    assign commit_done    = r_commit_done;
    assign cfg_error      = r_cfg_error;

endmodule
`default_nettype wire

// File: tb/tb_rca_config_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_config_bank
// Description : Self-checking bench for rca_config_bank (three RCAs so that an
//               out-of-range RCA index is expressible on a 2-bit select).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_config_bank;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic        cfg_valid    = 1'b0;
    logic [2:0]  cfg_type     = 3'd0;
    logic [1:0]  cfg_rca      = 2'd0;
    logic        cfg_src_dest = 1'b0;
    logic [7:0]  cfg_addr     = 8'd0;
    logic [7:0]  cfg_data     = 8'd0;
    logic [2:0]  rca_busy     = 3'b000;
    logic [1:0]  use_rca_sel  = 2'd0;

    logic        cfg_ready;
    logic [24:0] src_reg_addrs;
    logic [9:0]  dest_reg_addrs;
    logic [47:0] grid_mux_sels;
    logic [11:0] io_mux_sels;
    logic [3:0]  result_mux_sels;
    logic [2:0]  commit_pending;
    logic [2:0]  commit_done;
    logic        cfg_error;

    rca_config_bank #(.NUM_RCAS(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_type        (cfg_type),
        .cfg_rca         (cfg_rca),
        .cfg_src_dest    (cfg_src_dest),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .rca_busy        (rca_busy),
        .use_rca_sel     (use_rca_sel),
        .src_reg_addrs   (src_reg_addrs),
        .dest_reg_addrs  (dest_reg_addrs),
        .grid_mux_sels   (grid_mux_sels),
        .io_mux_sels     (io_mux_sels),
        .result_mux_sels (result_mux_sels),
        .commit_pending  (commit_pending),
        .commit_done     (commit_done),
        .cfg_error       (cfg_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       err;
        logic [2:0] done;
    } exp_t;

    typedef struct {
        logic [2:0]  typ;
        logic [1:0]  rca;
        logic        sd;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        err;
        logic [2:0]  done;
        logic        rd;
        logic [1:0]  sel;
        logic [24:0] src;
        logic [9:0]  dst;
        logic [47:0] grid;
        logic [11:0] io;
        logic [3:0]  res;
    } vec_t;

    exp_t       q[$];
    vec_t       tv[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         cyc    = 0;
    bit         mon_en = 1'b0;
    logic       m_err;
    logic [2:0] m_done;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Pulse outputs are compared every cycle; expected pulses come off the queue.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mon_en) begin
                m_err  = 1'b0;
                m_done = 3'b000;
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    m_err  = q[0].err;
                    m_done = q[0].done;
                    void'(q.pop_front());
                end
                chk("cfg_error", 64'(cfg_error), 64'(m_err));
                chk("commit_done", 64'(commit_done), 64'(m_done));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] t, input logic [1:0] r, input logic sd,
                         input logic [7:0] a, input logic [7:0] d,
                         input logic err, input logic [2:0] done);
        int w = 0;
        cfg_valid = 1'b1; cfg_type = t; cfg_rca = r; cfg_src_dest = sd;
        cfg_addr = a; cfg_data = d;
        #1;
        while (!cfg_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("accept_stall_cycles", 64'(w), 64'(0));
        q.push_back(exp_t'{cyc + 1, err, done});
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [1:0] s, input logic [24:0] es,
                      input logic [9:0] ed, input logic [47:0] eg,
                      input logic [11:0] ei, input logic [3:0] er);
        use_rca_sel = s;
        #1;
        chk({nm, ".src"},  64'(src_reg_addrs),   64'(es));
        chk({nm, ".dst"},  64'(dest_reg_addrs),  64'(ed));
        chk({nm, ".grid"}, 64'(grid_mux_sels),   64'(eg));
        chk({nm, ".io"},   64'(io_mux_sels),     64'(ei));
        chk({nm, ".res"},  64'(result_mux_sels), 64'(er));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv.push_back(vec_t'{3'd0, 2'd0, 1'b0, 8'd2,  8'h0B, 1'b0, 3'b000, 1'b1, 2'd0, 25'h0,    10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd4, 2'd0, 1'b0, 8'd0,  8'h00, 1'b0, 3'b001, 1'b1, 2'd0, 25'h2C00, 10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd1, 2'd1, 1'b0, 8'd15, 8'h05, 1'b0, 3'b000, 1'b1, 2'd1, 25'h0,    10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd6, 2'd0, 1'b0, 8'd0,  8'h01, 1'b1, 3'b000, 1'b1, 2'd0, 25'h2C00, 10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd2, 2'd0, 1'b0, 8'd4,  8'h01, 1'b1, 3'b000, 1'b0, 2'd0, 25'h0,    10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd0, 2'd3, 1'b0, 8'd0,  8'h01, 1'b1, 3'b000, 1'b0, 2'd0, 25'h0,    10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd4, 2'd3, 1'b0, 8'd0,  8'h00, 1'b1, 3'b000, 1'b0, 2'd0, 25'h0,    10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd0, 2'd0, 1'b1, 8'd2,  8'h01, 1'b1, 3'b000, 1'b0, 2'd0, 25'h0,    10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd3, 2'd0, 1'b0, 8'd1,  8'h03, 1'b0, 3'b000, 1'b0, 2'd0, 25'h0,    10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd2, 2'd0, 1'b0, 8'd3,  8'hFF, 1'b0, 3'b000, 1'b0, 2'd0, 25'h0,    10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd0, 2'd0, 1'b1, 8'd1,  8'h3F, 1'b0, 3'b000, 1'b0, 2'd0, 25'h0,    10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd1, 2'd0, 1'b0, 8'd0,  8'h0E, 1'b0, 3'b000, 1'b1, 2'd0, 25'h2C00, 10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd4, 2'd0, 1'b0, 8'd0,  8'h00, 1'b0, 3'b001, 1'b1, 2'd0, 25'h2C00, 10'h3E0, 48'h6,            12'hE00, 4'hC});
        tv.push_back(vec_t'{3'd1, 2'd2, 1'b0, 8'd16, 8'h01, 1'b1, 3'b000, 1'b0, 2'd0, 25'h0,    10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd0, 2'd0, 1'b0, 8'd5,  8'h01, 1'b1, 3'b000, 1'b0, 2'd0, 25'h0,    10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd3, 2'd0, 1'b0, 8'd2,  8'h01, 1'b1, 3'b000, 1'b1, 2'd0, 25'h2C00, 10'h3E0, 48'h6,            12'hE00, 4'hC});
        tv.push_back(vec_t'{3'd2, 2'd2, 1'b0, 8'd0,  8'h03, 1'b0, 3'b000, 1'b0, 2'd0, 25'h0,    10'h0,   48'h0,            12'h0,   4'h0});
        tv.push_back(vec_t'{3'd4, 2'd2, 1'b0, 8'd0,  8'h00, 1'b0, 3'b100, 1'b1, 2'd2, 25'h0,    10'h0,   48'h0,            12'h3,   4'h0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state
        #1;
        chk("reset.cfg_ready", 64'(cfg_ready), 64'(1));
        chk("reset.pending", 64'(commit_pending), 64'(0));
        rd("reset.rca0", 2'd0, 25'h0, 10'h0, 48'h0, 12'h0, 4'h0);
        rd("reset.rca1", 2'd1, 25'h0, 10'h0, 48'h0, 12'h0, 4'h0);
        @(negedge clk);

        foreach (tv[i]) begin
            issue(tv[i].typ, tv[i].rca, tv[i].sd, tv[i].addr, tv[i].data, tv[i].err, tv[i].done);
            if (tv[i].rd)
                rd($sformatf("vec%0d", i), tv[i].sel, tv[i].src, tv[i].dst, tv[i].grid, tv[i].io, tv[i].res);
        end
        @(negedge clk);

        // Commit RCA1 while busy: stays pending, stalls RCA1 commands only
        rca_busy = 3'b010;
        issue(3'd4, 2'd1, 1'b0, 8'd0, 8'h00, 1'b0, 3'b000);
        chk("pend.pending_set", 64'(commit_pending), 64'(3'b010));
        rd("pend.rca1_unchanged", 2'd1, 25'h0, 10'h0, 48'h0, 12'h0, 4'h0);
        cfg_valid = 1'b1; cfg_type = 3'd0; cfg_rca = 2'd1; cfg_src_dest = 1'b0;
        cfg_addr = 8'd0; cfg_data = 8'h11;
        #1;
        chk("pend.ready_rca1", 64'(cfg_ready), 64'(0));
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pend.ready_rca1_held", 64'(cfg_ready), 64'(0));
        chk("pend.still_pending", 64'(commit_pending), 64'(3'b010));
        cfg_rca = 2'd3;
        #1;
        chk("pend.ready_rca3", 64'(cfg_ready), 64'(1));
        cfg_rca = 2'd1;
        #1;
        issue(3'd3, 2'd0, 1'b0, 8'd0, 8'h02, 1'b0, 3'b000);
        chk("pend.pending_after_rca0", 64'(commit_pending), 64'(3'b010));
        rca_busy = 3'b000;
        q.push_back(exp_t'{cyc + 1, 1'b0, 3'b010});
        @(negedge clk);
        #1;
        chk("pend.released", 64'(commit_pending), 64'(0));
        rd("pend.rca1_active", 2'd1, 25'h0, 10'h0, 48'hA00000000000, 12'h0, 4'h0);
        @(negedge clk);
        issue(3'd0, 2'd1, 1'b0, 8'd0, 8'h11, 1'b0, 3'b000);
        issue(3'd4, 2'd1, 1'b0, 8'd0, 8'h00, 1'b0, 3'b010);
        rd("pend.rca1_recommit", 2'd1, 25'h11, 10'h0, 48'hA00000000000, 12'h0, 4'h0);

        // Commit and read of the same RCA in one cycle: old value until the edge
        @(negedge clk);
        issue(3'd0, 2'd0, 1'b0, 8'd0, 8'h07, 1'b0, 3'b000);
        use_rca_sel = 2'd0;
        cfg_valid = 1'b1; cfg_type = 3'd4; cfg_rca = 2'd0;
        #1;
        chk("same_cycle.old_src", 64'(src_reg_addrs), 64'(25'h2C00));
        q.push_back(exp_t'{cyc + 1, 1'b0, 3'b001});
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        rd("same_cycle.new", 2'd0, 25'h2C07, 10'h3E0, 48'h6, 12'hE00, 4'hE);
        rd("sel_out_of_range", 2'd3, 25'h0, 10'h0, 48'h0, 12'h0, 4'h0);

        // Asynchronous reset while RCA0 is pending with a nonzero shadow
        @(negedge clk);
        rca_busy = 3'b001;
        issue(3'd4, 2'd0, 1'b0, 8'd0, 8'h00, 1'b0, 3'b000);
        chk("rst.pending_before", 64'(commit_pending), 64'(3'b001));
        use_rca_sel = 2'd0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst.pending_cleared", 64'(commit_pending), 64'(0));
        chk("rst.src_cleared", 64'(src_reg_addrs), 64'(0));
        chk("rst.grid_cleared", 64'(grid_mux_sels), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        rca_busy = 3'b000;
        issue(3'd4, 2'd0, 1'b0, 8'd0, 8'h00, 1'b0, 3'b001);
        rd("rst.zero_commit", 2'd0, 25'h0, 10'h0, 48'h0, 12'h0, 4'h0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'(0));
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
